// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle ARM controller (master) and its datapath (slave).
interface multicycle_controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        mem_ready;
    logic        PCWrite;
    logic        IRWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        AdrSrc;
    logic [1:0]  ResultSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUControl;
    logic [3:0]  state;

    modport master (
        input  Instr, ALUFlags, mem_ready,
        output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, state
    );

    modport slave (
        output Instr, ALUFlags, mem_ready,
        input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: main FSM, ALU decode, ImmSrc/RegSrc decode and condition logic.
// Optional macro MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE stall until mem_ready.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    reset_n,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_UNKNOWN  = 4'd10;

    logic [3:0] state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] unused_instr;
    logic       mem_go;

    assign cond         = bus.Instr[19:16];
    assign op           = bus.Instr[15:14];
    assign funct        = bus.Instr[13:8];
    assign rd           = bus.Instr[3:0];
    assign unused_instr = bus.Instr[7:4];

`ifdef MEM_WAIT_EN
    assign mem_go = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign mem_go           = 1'b1;
    assign unused_mem_ready = bus.mem_ready;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_go) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_go) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_go) state_d = S_FETCH;
            S_EXECUTER,
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    logic       next_pc, ir_write, mem_w, reg_w, branch, alu_op;
    logic       adr_src, alu_src_a;
    logic [1:0] result_src, alu_src_b;

    always_comb begin
        next_pc    = 1'b0;
        ir_write   = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        result_src = 2'b00;
        alu_src_b  = 2'b00;
        case (state_q)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_go;
                next_pc    = mem_go;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_MEMADR:   alu_src_b = 2'b01;
            S_MEMREAD:  adr_src   = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXECUTER: alu_op = 1'b1;
            S_EXECUTEI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
            end
            S_ALUWB:    reg_w = 1'b1;
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: ;
        endcase
    end

    logic [1:0] alu_control;
    logic [1:0] flag_w;

    // Unrecognised commands execute as ADD, so they also count as arithmetic for C/V.
    always_comb begin
        alu_control = 2'b00;
        flag_w      = 2'b00;
        if (alu_op) begin
            case (funct[4:1])
                4'b0100: alu_control = 2'b00;
                4'b0010: alu_control = 2'b01;
                4'b0000: alu_control = 2'b10;
                4'b1100: alu_control = 2'b11;
                default: alu_control = 2'b00;
            endcase
            flag_w[1] = funct[0];
            flag_w[0] = funct[0] & ~alu_control[1];
        end
    end

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_ok;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        case (cond)
            4'b0000: cond_ok = flag_z;
            4'b0001: cond_ok = ~flag_z;
            4'b0010: cond_ok = flag_c;
            4'b0011: cond_ok = ~flag_c;
            4'b0100: cond_ok = flag_n;
            4'b0101: cond_ok = ~flag_n;
            4'b0110: cond_ok = flag_v;
            4'b0111: cond_ok = ~flag_v;
            4'b1000: cond_ok = flag_c & ~flag_z;
            4'b1001: cond_ok = ~flag_c | flag_z;
            4'b1010: cond_ok = (flag_n == flag_v);
            4'b1011: cond_ok = (flag_n != flag_v);
            4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ok = flag_z | (flag_n != flag_v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    logic in_execute;
    assign in_execute = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);

    always_comb begin
        condex_d = (state_q == S_DECODE) ? cond_ok : condex_q;
        flags_d  = flags_q;
        if (in_execute && condex_q) begin
            if (flag_w[1]) flags_d[3:2] = bus.ALUFlags[3:2];
            if (flag_w[0]) flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    // Enables are gated by reset_n so nothing is written while reset is held.
    logic pcs;
    assign pcs = branch | (reg_w & (rd == 4'hF));

    assign bus.PCWrite    = reset_n & (next_pc | (pcs & condex_q));
    assign bus.IRWrite    = reset_n & ir_write;
    assign bus.RegWrite   = reset_n & reg_w & condex_q;
    assign bus.MemWrite   = reset_n & mem_w & condex_q;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
    assign bus.ALUControl = alu_control;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction-level reference model, directed and random programs.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset_n;

    multicycle_controller_if io();

    multicycle_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (io)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed / expected per-cycle control vectors for one instruction
    logic [19:0] obs_v [0:7];
    logic [19:0] exp_v [0:7];
    int          n_obs;
    int          n_exp;
    logic [3:0]  m_flags;

    function automatic logic [19:0] pk(input logic [31:0] i);
        return {i[31:28], i[27:26], i[25:20], i[19:16], i[15:12]};
    endfunction

    // {state, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl}
    function automatic logic [19:0] ev(input logic [3:0] st, input logic pcw, input logic irw,
                                       input logic mw, input logic rw, input logic adr,
                                       input logic [1:0] res, input logic a, input logic [1:0] b,
                                       input logic [1:0] imm, input logic [1:0] rs, input logic [1:0] aluc);
        return {st, pcw, irw, mw, rw, adr, res, a, b, imm, rs, aluc};
    endfunction

    function automatic logic [19:0] sample_outputs();
        return ev(io.state, io.PCWrite, io.IRWrite, io.MemWrite, io.RegWrite, io.AdrSrc,
                  io.ResultSrc, io.ALUSrcA, io.ALUSrcB, io.ImmSrc, io.RegSrc, io.ALUControl);
    endfunction

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;              // EQ
            4'h1: return !z;             // NE
            4'h2: return cy;             // CS
            4'h3: return !cy;            // CC
            4'h4: return n;              // MI
            4'h5: return !n;             // PL
            4'h6: return v;              // VS
            4'h7: return !v;             // VC
            4'h8: return cy && !z;       // HI
            4'h9: return !cy || z;       // LS
            4'hA: return n == v;         // GE
            4'hB: return n != v;         // LT
            4'hC: return !z && (n == v); // GT
            4'hD: return z || (n != v);  // LE
            4'hE: return 1'b1;           // AL
            default: return 1'b0;
        endcase
    endfunction

    // Reference: expected cycle sequence for one instruction, updating the architectural flags
    task automatic model_instr(input logic [19:0] ins, input logic [3:0] af);
        logic [1:0] op, imm, rs, aluc;
        logic [5:0] f;
        logic       ok, to_pc, arith;
        op    = ins[15:14];
        f     = ins[13:8];
        ok    = cond_holds(ins[19:16], m_flags);
        to_pc = ok && (ins[3:0] == 4'hF);
        imm   = op;
        rs    = {op == 2'b01, op == 2'b10};
        exp_v[0] = ev(4'd0, 1, 1, 0, 0, 0, 2'b10, 1, 2'b10, imm, rs, 2'b00);
        exp_v[1] = ev(4'd1, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, imm, rs, 2'b00);
        case (op)
            2'b00: begin
                case (f[4:1])
                    4'b0010: begin aluc = 2'b01; arith = 1'b1; end
                    4'b0000: begin aluc = 2'b10; arith = 1'b0; end
                    4'b1100: begin aluc = 2'b11; arith = 1'b0; end
                    default: begin aluc = 2'b00; arith = 1'b1; end
                endcase
                exp_v[2] = ev(f[5] ? 4'd7 : 4'd6, 0, 0, 0, 0, 0, 2'b00, 0, f[5] ? 2'b01 : 2'b00, imm, rs, aluc);
                exp_v[3] = ev(4'd8, to_pc, 0, 0, ok, 0, 2'b00, 0, 2'b00, imm, rs, 2'b00);
                n_exp = 4;
                if (ok && f[0]) begin
                    m_flags[3:2] = af[3:2];
                    if (arith) m_flags[1:0] = af[1:0];
                end
            end
            2'b01: begin
                exp_v[2] = ev(4'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, imm, rs, 2'b00);
                if (f[0]) begin
                    exp_v[3] = ev(4'd3, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, imm, rs, 2'b00);
                    exp_v[4] = ev(4'd4, to_pc, 0, 0, ok, 0, 2'b01, 0, 2'b00, imm, rs, 2'b00);
                    n_exp = 5;
                end else begin
                    exp_v[3] = ev(4'd5, 0, 0, ok, 0, 1, 2'b00, 0, 2'b00, imm, rs, 2'b00);
                    n_exp = 4;
                end
            end
            2'b10: begin
                exp_v[2] = ev(4'd9, ok, 0, 0, 0, 0, 2'b10, 0, 2'b01, imm, rs, 2'b00);
                n_exp = 3;
            end
            default: begin
                exp_v[2] = ev(4'd10, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, imm, rs, 2'b00);
                n_exp = 3;
            end
        endcase
    endtask

    // Starts just after a clock edge with the DUT in FETCH; returns once it is back in FETCH
    task automatic exec_instr(input logic [19:0] ins, input logic [3:0] af);
        io.Instr    = ins;
        io.ALUFlags = af;
        n_obs = 0;
        do begin
`ifdef MEM_WAIT_EN
            io.mem_ready = 1'b1;
`else
            io.mem_ready = 1'($urandom_range(0, 1));
`endif
            @(negedge clk);
            obs_v[n_obs] = sample_outputs();
            n_obs++;
            @(posedge clk);
            #1;
        end while (io.state != 4'd0 && n_obs < 8);
    endtask

    task automatic test_reset();
        logic [19:0] ins;
        logic [19:0] want;
        reset_n      = 1'b0;
        io.ALUFlags  = 4'h0;
        io.mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ins      = pk($urandom);
            io.Instr = ins;
            #3;
            want = ev(4'd0, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, ins[15:14],
                      {ins[15:14] == 2'b01, ins[15:14] == 2'b10}, 2'b00);
            n_cmp++;
            if (sample_outputs() !== want) begin
                n_bad++;
                $display("FAIL reset_outputs #%0d: got %h, expected %h", k, sample_outputs(), want);
            end
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_flags = 4'h0;
    endtask

    task automatic test_directed(input string name, input int cnt,
                                 input logic [31:0] prog [0:7], input logic [3:0] fl [0:7]);
        for (int k = 0; k < cnt; k++) begin
            exec_instr(pk(prog[k]), fl[k]);
            model_instr(pk(prog[k]), fl[k]);
            n_cmp++;
            if (n_obs !== n_exp) begin
                n_bad++;
                $display("FAIL %s_len instr %h: got %0d cycles, expected %0d", name, prog[k], n_obs, n_exp);
            end
            for (int i = 0; i < n_exp && i < n_obs; i++) begin
                n_cmp++;
                if (obs_v[i] !== exp_v[i]) begin
                    n_bad++;
                    $display("FAIL %s instr %h cycle %0d: got %h, expected %h", name, prog[k], i, obs_v[i], exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_data_processing();
        logic [31:0] prog [0:7];
        logic [3:0]  fl   [0:7];
        // ADD, SUBS #1 (Z), AND, ORR, ADD to PC, ADDS with unrecognised-looking flags
        prog = '{32'hE0821003, 32'hE2511001, 32'hE0021003, 32'hE1821003,
                 32'hE082F003, 32'hE0921003, 32'hE0121003, 32'hE1921003};
        fl   = '{4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'hB, 4'h8, 4'h4};
        test_directed("dp", 8, prog, fl);
    endtask

    task automatic test_branch();
        logic [31:0] prog [0:7];
        logic [3:0]  fl   [0:7];
        // SUBS Z=1; BEQ taken; SUBSNE skipped; BEQ taken; SUBS Z=0; BEQ not taken; BNE taken; B never
        prog = '{32'hE2511001, 32'h0A000002, 32'h12511001, 32'h0A000002,
                 32'hE2511001, 32'h0A000002, 32'h1A000002, 32'hFA000002};
        fl   = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        test_directed("branch", 8, prog, fl);
    endtask

    task automatic test_memory();
        logic [31:0] prog [0:7];
        logic [3:0]  fl   [0:7];
        // LDR, STR, LDR to PC, STRNE, STREQ, LDREQ, SUBS Z=1, LDREQ
        prog = '{32'hE5910008, 32'hE5810008, 32'hE591F008, 32'h15810008,
                 32'h05810008, 32'h05910008, 32'hE2511001, 32'h05910008};
        fl   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0};
        test_directed("mem", 8, prog, fl);
    endtask

    task automatic test_reset_midway();
        logic [31:0] prog [0:7];
        logic [3:0]  fl   [0:7];
        logic [19:0] want;
        prog = '{32'hE2511001, 32'h0A000002, 32'h1A000002, 32'hE0821003,
                 32'h0, 32'h0, 32'h0, 32'h0};
        fl   = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        test_directed("pre_rst", 1, prog, fl);
        // ADDS with all flags set, interrupted in EXECUTER
        io.Instr    = pk(32'hE0921003);
        io.ALUFlags = 4'hF;
        io.mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++;
        if (io.state !== 4'd6) begin
            n_bad++;
            $display("FAIL midrst_reach: got state %0d, expected 6", io.state);
        end
        #1;
        reset_n = 1'b0;
        #1;
        want = ev(4'd0, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00);
        n_cmp++;
        if (sample_outputs() !== want) begin
            n_bad++;
            $display("FAIL midrst_async: got %h, expected %h", sample_outputs(), want);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_flags = 4'h0;
        // Flags cleared: BEQ not taken, BNE taken, plain ADD completes normally
        prog[0] = prog[1];
        prog[1] = prog[2];
        prog[2] = prog[3];
        test_directed("post_rst", 3, prog, fl);
    endtask

    task automatic test_random();
        logic [19:0] ins;
        logic [3:0]  af;
        for (int k = 0; k < 300; k++) begin
            ins = pk($urandom);
            af  = 4'($urandom_range(0, 15));
            exec_instr(ins, af);
            model_instr(ins, af);
            n_cmp++;
            if (n_obs !== n_exp) begin
                n_bad++;
                $display("FAIL rand_len #%0d instr %h: got %0d cycles, expected %0d", k, ins, n_obs, n_exp);
            end
            for (int i = 0; i < n_exp && i < n_obs; i++) begin
                n_cmp++;
                if (obs_v[i] !== exp_v[i]) begin
                    n_bad++;
                    $display("FAIL rand #%0d instr %h cycle %0d: got %h, expected %h", k, ins, i, obs_v[i], exp_v[i]);
                end
            end
        end
    endtask

`ifdef MEM_WAIT_EN
    task automatic test_mem_wait();
        io.Instr     = pk(32'hFA000002);
        io.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (io.state !== 4'd0 || io.PCWrite !== 1'b0 || io.IRWrite !== 1'b0) begin
                n_bad++;
                $display("FAIL wait_hold #%0d: got state=%0d pcw=%b irw=%b, expected 0 0 0", k, io.state, io.PCWrite, io.IRWrite);
            end
        end
        io.mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (io.PCWrite !== 1'b1 || io.IRWrite !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_ready: got pcw=%b irw=%b, expected 1 1", io.PCWrite, io.IRWrite);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        reset_n  = 1'b0;
        m_flags  = 4'h0;
        io.Instr = '0;
        test_reset();
`ifdef MEM_WAIT_EN
        test_mem_wait();
`endif
        test_data_processing();
        test_branch();
        test_memory();
        test_reset_midway();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
